// File: rtl/dac_ddr_pkg.sv
// Shared definitions for the DAC DDR transmit path: lane geometry, FSM states,
// default words and PRBS7 helpers (used when DAC_TX_PRBS_EN is defined).
package dac_ddr_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] TRAIN_PATTERN_DEF = 16'hA55A;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF     = 16'h0000;

  // x^7 + x^6 + 1: feedback taps are state bits 6 and 5
  localparam logic [6:0] PRBS7_POLY = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_PRIME  = 2'd2,
    ST_STREAM = 2'd3
  } dac_state_e;

  // Sixteen PRBS7 output bits from state s, first bit in the MSB
  function automatic logic [WORD_W-1:0] prbs7_word(input logic [6:0] s);
    logic [6:0]        t;
    logic [WORD_W-1:0] w;
    logic              fb;
    t = s;
    w = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      fb            = ^(t & PRBS7_POLY);
      w[WORD_W-1-i] = fb;
      t             = {t[5:0], fb};
    end
    return w;
  endfunction

  function automatic logic [6:0] prbs7_adv(input logic [6:0] s);
    logic [6:0] t;
    t = s;
    for (int i = 0; i < int'(WORD_W); i++) begin
      t = {t[5:0], ^(t & PRBS7_POLY)};
    end
    return t;
  endfunction

endpackage

// File: rtl/OBUFDS.sv
// Behavioural stand-in for the vendor OBUFDS differential output buffer.
module OBUFDS (
  output logic O,
  output logic OB,
  input  logic I
);

  assign O  = I;
  assign OB = ~I;

endmodule

// File: rtl/ODDRE1.sv
// Behavioural stand-in for the vendor ODDRE1 output DDR register; the unisim
// library model replaces it in implementation.
module ODDRE1 #(
  parameter logic IS_C_INVERTED  = 1'b0,
  parameter logic IS_D1_INVERTED = 1'b0,
  parameter logic IS_D2_INVERTED = 1'b0,
  parameter logic SRVAL          = 1'b0
) (
  output logic Q,
  input  logic C,
  input  logic D1,
  input  logic D2,
  input  logic SR
);

  logic c_i;
  logic d1_q;
  logic d2_q;

  assign c_i = C ^ IS_C_INVERTED;

  // Both halves captured on the rising edge; D2 is shown in the low phase
  always_ff @(posedge c_i or posedge SR) begin
    if (SR) begin
      d1_q <= SRVAL;
      d2_q <= SRVAL;
    end else begin
      d1_q <= D1 ^ IS_D1_INVERTED;
      d2_q <= D2 ^ IS_D2_INVERTED;
    end
  end

  assign Q = c_i ? d1_q : d2_q;

endmodule

// File: rtl/dac_tx_fifo.sv
// Synchronous FIFO with async reset, flush, level and registered not-full.
// No fall-through: a word written this cycle becomes poppable next cycle.
module dac_tx_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [LW-1:0]    level_nxt;

  assign push_ok   = push & ready & ~flush;
  assign pop_ok    = pop & (level != '0) & ~flush;
  assign level_nxt = level + LW'(push_ok) - LW'(pop_ok);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      ready <= (level_nxt < LW'(DEPTH));
    end
  end

endmodule

// File: rtl/dac_ddr_tx.sv
// DAC transmit path: FIFO, link-training sequencer and 8-lane DDR serialiser.
// Define DAC_TX_PRBS_EN to train with PRBS7 instead of the fixed pattern.
module dac_ddr_tx
  import dac_ddr_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH    = 16,
  parameter int unsigned       TRAIN_CYCLES  = 64,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD     = IDLE_WORD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          train_req,
  input  logic [WORD_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          training,
  output logic [15:0]                   underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          dac_clk_p,
  output logic                          dac_clk_n,
  output logic [LANES-1:0]              dac_p,
  output logic [LANES-1:0]              dac_n
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;

  dac_state_e        state;
  dac_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WORD_W-1:0] tx_word;
  logic [WORD_W-1:0] tx_nxt;
  logic [WORD_W-1:0] train_word;
  logic [WORD_W-1:0] fifo_rdata;
  logic              pop;
  logic              uf_inc;
  logic              flush;
  logic              push;
  logic [LANES-1:0]  lane_q;
  logic              fclk_q;

  assign flush = (state == ST_IDLE) | ~enable;
  assign push  = s_valid & s_ready & ~flush;

  dac_tx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .ready (s_ready)
  );

  // Next state, training counter, next tx word and pop decision
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tx_nxt    = IDLE_WORD;
    pop       = 1'b0;
    uf_inc    = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_TRAIN;
          cnt_nxt   = '0;
        end
        ST_TRAIN: begin
          tx_nxt = train_word;
          if (train_req) begin
            cnt_nxt = '0;
          end else if (cnt == CNT_W'(TRAIN_CYCLES - 1)) begin
            state_nxt = ST_PRIME;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_PRIME: begin
          if (train_req) begin
            state_nxt = ST_TRAIN;
            cnt_nxt   = '0;
          end else if (fifo_level >= LVL_W'(FIFO_DEPTH / 2)) begin
            state_nxt = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (train_req) begin
            state_nxt = ST_TRAIN;
            cnt_nxt   = '0;
          end else if (fifo_level != '0) begin
            pop    = 1'b1;
            tx_nxt = fifo_rdata;
          end else begin
            uf_inc = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      tx_word       <= IDLE_WORD;
      training      <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tx_word  <= tx_nxt;
      training <= (state_nxt == ST_TRAIN);
      if (uf_inc && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

`ifdef DAC_TX_PRBS_EN
  logic [6:0] lfsr;
  logic       reseed;

  // Entering TRAIN (or restarting it) starts the sequence from the seed
  assign reseed = (state_nxt == ST_TRAIN) && ((state != ST_TRAIN) || train_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lfsr <= PRBS7_SEED;
    else if (reseed)            lfsr <= PRBS7_SEED;
    else if (state == ST_TRAIN) lfsr <= prbs7_adv(lfsr);
  end

  assign train_word = prbs7_word(lfsr);
`else
  assign train_word = TRAIN_PATTERN;
`endif

  // Lane i: even bit on the rising edge, odd bit on the falling edge
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    ODDRE1 #(
      .IS_C_INVERTED  (1'b0),
      .IS_D1_INVERTED (1'b0),
      .IS_D2_INVERTED (1'b0),
      .SRVAL          (1'b0)
    ) u_oddr (
      .Q  (lane_q[i]),
      .C  (clk),
      .D1 (tx_word[2*i]),
      .D2 (tx_word[2*i+1]),
      .SR (rst)
    );

    OBUFDS u_obuf (
      .O  (dac_p[i]),
      .OB (dac_n[i]),
      .I  (lane_q[i])
    );
  end

  ODDRE1 #(
    .IS_C_INVERTED  (1'b0),
    .IS_D1_INVERTED (1'b0),
    .IS_D2_INVERTED (1'b0),
    .SRVAL          (1'b0)
  ) u_oddr_clk (
    .Q  (fclk_q),
    .C  (clk),
    .D1 (1'b1),
    .D2 (1'b0),
    .SR (rst)
  );

  OBUFDS u_obuf_clk (
    .O  (dac_clk_p),
    .OB (dac_clk_n),
    .I  (fclk_q)
  );

endmodule

// File: tb/tb_dac_ddr_tx.sv
// Bench for dac_ddr_tx: randomized stimulus against a queue-based reference
// model, with the lane pins deserialised the way the ADC-side IDDR would.
module tb_dac_ddr_tx;

  localparam int          DEPTH = 16;
  localparam int          TC    = 64;
  localparam logic [15:0] IDLEW = 16'h0000;
  localparam logic [15:0] PAT   = 16'hA55A;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        train_req;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        training;
  logic [15:0] underflow_cnt;
  logic [4:0]  fifo_level;
  logic        dac_clk_p;
  logic        dac_clk_n;
  logic [7:0]  dac_p;
  logic [7:0]  dac_n;

  dac_ddr_tx dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .train_req     (train_req),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .training      (training),
    .underflow_cnt (underflow_cnt),
    .fifo_level    (fifo_level),
    .dac_clk_p     (dac_clk_p),
    .dac_clk_n     (dac_clk_n),
    .dac_p         (dac_p),
    .dac_n         (dac_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: link phase 0=idle 1=train 2=prime 3=stream
  int          m_st;
  int          m_cnt;
  logic [15:0] m_q[$];
  int          m_uf;
  bit          m_rdy;
  logic [15:0] m_tx;
  logic [15:0] m_pin;

  logic [15:0] obs_pin;
  bit          obs_phy_ok;
  bit          trn_d1;
  bit          trn_d2;
  bit          collect;
  logic [15:0] rec[$];
  logic [15:0] acc[$];

`ifdef DAC_TX_PRBS_EN
  bit pb[16*TC+7];
  initial begin
    for (int j = 0; j < 7; j++) pb[j] = 1'b1;
    for (int n = 7; n < 16*TC+7; n++) pb[n] = pb[n-7] ^ pb[n-6];
  end
`endif

  // k-th training word after entry to TRAIN
  function automatic logic [15:0] train_word(input int k);
    logic [15:0] w;
`ifdef DAC_TX_PRBS_EN
    for (int i = 0; i < 16; i++) w[15-i] = pb[7 + 16*k + i];
`else
    w = PAT;
`endif
    return w;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_q.delete(); m_uf = 0; m_rdy = 1'b0;
    m_tx = IDLEW; m_pin = 16'h0000; trn_d1 = 1'b0; trn_d2 = 1'b0;
  endtask

  // Drive one clock of inputs, advance the model, deserialise the pins
  task automatic cycle(input bit en, input bit tr, input bit v, input logic [15:0] d);
    bit          flush, push;
    int          nx_st, nx_cnt;
    logic [15:0] nx_tx, hi, lo;
    bit          chi, clo, nok;
    enable = en; train_req = tr; s_valid = v; s_data = d;
    flush  = (m_st == 0) || !en;
    push   = v && m_rdy && !flush;
    nx_st  = m_st; nx_cnt = m_cnt; nx_tx = IDLEW;
    if (!en) nx_st = 0;
    else if (m_st == 0) begin nx_st = 1; nx_cnt = 0; end
    else if (m_st == 1) begin
      nx_tx = train_word(m_cnt);
      if (tr) nx_cnt = 0;
      else if (m_cnt == TC-1) nx_st = 2;
      else nx_cnt = m_cnt + 1;
    end else if (tr) begin nx_st = 1; nx_cnt = 0; end
    else if (m_st == 2) begin
      if (m_q.size() >= DEPTH/2) nx_st = 3;
    end else begin
      if (m_q.size() > 0) nx_tx = m_q.pop_front();
      else if (m_uf < 65535) m_uf++;
    end
    if (flush) m_q.delete();
    else if (push) m_q.push_back(d);
    m_rdy = (m_q.size() < DEPTH);
    m_pin = m_tx; m_tx = nx_tx; m_st = nx_st; m_cnt = nx_cnt;
    @(posedge clk); #2;
    hi = {8'h00, dac_p}; chi = dac_clk_p; nok = (dac_n === ~dac_p);
    @(negedge clk); #2;
    lo = {8'h00, dac_p}; clo = dac_clk_p; nok = nok && (dac_n === ~dac_p);
    for (int i = 0; i < 8; i++) begin
      obs_pin[2*i]   = hi[i];
      obs_pin[2*i+1] = lo[i];
    end
    obs_phy_ok = nok && (chi === 1'b1) && (clo === 1'b0);
    if (collect && !trn_d2 && obs_pin != 16'h0000) rec.push_back(obs_pin);
    trn_d2 = trn_d1; trn_d1 = training;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; train_req = 1'b0; s_valid = 1'b0; s_data = '0;
    collect = 1'b0;
    model_reset();
    #23;
    checks++; if (training !== 1'b0) begin errors++; $display("FAIL reset_training got %b exp 0", training); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_uf got %0d exp 0", underflow_cnt); end
    checks++; if (dac_p !== 8'h00 || dac_clk_p !== 1'b0) begin errors++; $display("FAIL reset_pins got %h/%b exp 00/0", dac_p, dac_clk_p); end
    @(negedge clk); rst = 1'b0; #2;
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    checks++; if (s_ready !== m_rdy) begin errors++; $display("FAIL post_reset_ready got %b exp %b", s_ready, m_rdy); end
  endtask

  task automatic test_train();
    int ntrain = 0;
    for (int c = 0; c < TC + 2; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      if (training === 1'b1) ntrain++;
      checks++; if (obs_pin !== m_pin || !obs_phy_ok) begin errors++; $display("FAIL train_pin cyc %0d got %h exp %h phy %b", c, obs_pin, m_pin, obs_phy_ok); end
    end
    checks++; if (ntrain != TC) begin errors++; $display("FAIL train_len got %0d exp %0d", ntrain, TC); end
    for (int k = 1; k <= 7; k++) cycle(1'b1, 1'b0, 1'b1, 16'(k));
    checks++; if (fifo_level !== 5'd7 || training !== 1'b0) begin errors++; $display("FAIL prime_hold level %0d trn %b exp 7 0", fifo_level, training); end
  endtask

  task automatic test_stream();
    rec.delete(); collect = 1'b1;
    for (int k = 8; k <= 256; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'(k));
      checks++; if (obs_pin !== m_pin || fifo_level !== 5'(m_q.size())) begin errors++; $display("FAIL stream k %0d pin %h exp %h lvl %0d exp %0d", k, obs_pin, m_pin, fifo_level, m_q.size()); end
    end
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL stream_uf got %0d exp 0", underflow_cnt); end
  endtask

  task automatic test_underflow();
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      checks++; if (underflow_cnt !== 16'(m_uf) || s_ready !== 1'b1 || obs_pin !== m_pin) begin
        errors++; $display("FAIL underflow cyc %0d uf %0d exp %0d rdy %b pin %h exp %h", c, underflow_cnt, m_uf, s_ready, obs_pin, m_pin);
      end
    end
    checks++; if (rec.size() != 256) begin errors++; $display("FAIL stream_count got %0d exp 256", rec.size()); end
    else begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (rec[i] !== 16'(i+1)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL stream_order got %0d wrong words exp 0", bad); end
    end
    collect = 1'b0;
  endtask

  task automatic test_fill();
    logic [15:0] d;
    cycle(1'b0, 1'b0, 1'b1, 16'h1234);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    checks++; if (fifo_level !== 5'd0 || training !== 1'b0 || underflow_cnt !== 16'(m_uf)) begin
      errors++; $display("FAIL disable lvl %0d trn %b uf %0d exp 0 0 %0d", fifo_level, training, underflow_cnt, m_uf);
    end
    acc.delete();
    for (int c = 0; c < TC; c++) begin
      d = 16'($urandom_range(1, 65535));
      if (m_rdy && m_st != 0) acc.push_back(d);
      cycle(1'b1, 1'b0, 1'b1, d);
    end
    checks++; if (fifo_level !== 5'd16 || s_ready !== 1'b0) begin errors++; $display("FAIL fill lvl %0d rdy %b exp 16 0", fifo_level, s_ready); end
    checks++; if (acc.size() != DEPTH) begin errors++; $display("FAIL fill_accepted got %0d exp %0d", acc.size(), DEPTH); end
  endtask

  task automatic test_train_req();
    int lvl;
    int ntrain = 0;
    rec.delete(); collect = 1'b1;
    for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
    lvl = m_q.size();
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (training !== 1'b1 || fifo_level !== 5'(lvl)) begin errors++; $display("FAIL train_req trn %b lvl %0d exp 1 %0d", training, fifo_level, lvl); end
    for (int c = 0; c < 100; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      if (training === 1'b1) ntrain++;
      checks++; if (obs_pin !== m_pin) begin errors++; $display("FAIL retrain_pin cyc %0d got %h exp %h", c, obs_pin, m_pin); end
    end
    checks++; if (ntrain != TC - 1) begin errors++; $display("FAIL retrain_len got %0d exp %0d", ntrain + 1, TC); end
    checks++; if (rec.size() != acc.size()) begin errors++; $display("FAIL resume_count got %0d exp %0d", rec.size(), acc.size()); end
    else begin
      int bad = 0;
      foreach (acc[i]) if (rec[i] !== acc[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL resume_order got %0d wrong words exp 0", bad); end
    end
    collect = 1'b0;
  endtask

  task automatic test_random();
    bit en, tr, v;
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom % 64) != 0;
      tr = ($urandom % 128) == 0;
      v  = ($urandom % 4) != 0;
      cycle(en, tr, v, 16'($urandom));
      checks++;
      if (obs_pin !== m_pin || training !== (m_st == 1) || fifo_level !== 5'(m_q.size()) ||
          s_ready !== m_rdy || underflow_cnt !== 16'(m_uf) || !obs_phy_ok) begin
        errors++;
        $display("FAIL random cyc %0d pin %h/%h trn %b/%b lvl %0d/%0d rdy %b/%b uf %0d/%0d phy %b",
                 c, obs_pin, m_pin, training, (m_st == 1), fifo_level, m_q.size(), s_ready, m_rdy,
                 underflow_cnt, m_uf, obs_phy_ok);
      end
    end
  endtask

  task automatic test_async_rst();
    for (int c = 0; c < 80; c++) cycle(1'b1, 1'b0, 1'b1, 16'($urandom_range(1, 65535)));
    @(posedge clk); #3 rst = 1'b1; #1;
    checks++;
    if (training !== 1'b0 || s_ready !== 1'b0 || fifo_level !== 5'd0 || underflow_cnt !== 16'd0 ||
        dac_p !== 8'h00 || dac_clk_p !== 1'b0) begin
      errors++;
      $display("FAIL async_rst trn %b rdy %b lvl %0d uf %0d pins %h clk %b exp all zero",
               training, s_ready, fifo_level, underflow_cnt, dac_p, dac_clk_p);
    end
    model_reset();
    enable = 1'b0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #2;
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    checks++; if (obs_pin !== train_word(0)) begin errors++; $display("FAIL first_train_word got %h exp %h", obs_pin, train_word(0)); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_stream();
    test_underflow();
    test_fill();
    test_train_req();
    test_random();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_ddr_tx.md
Name: dac_ddr_tx

Overview:
- Transmit-side counterpart of the ADC DDR capture path: accepts 16-bit parallel words on a valid/ready stream and serialises them onto 8 LVDS DDR lanes plus a forwarded DDR clock.
- Path per lane: register -> ODDRE1 -> OBUFDS.
- Contains an input FIFO, a link-training sequencer and underflow accounting.
- Sits between the DSP sample source and the DAC pins in the same clock domain as the ADC receiver.

Parameters:
FIFO_DEPTH, 16, input FIFO depth in words; power of 2, minimum 4
TRAIN_CYCLES, 64, number of clk cycles the training pattern is driven
TRAIN_PATTERN, 16'hA55A, word driven during TRAIN
IDLE_WORD, 16'h0000, word driven in IDLE/PRIME and on underflow

Ports:
clk  input  1  sample clock; also drives ODDRE1 C and the forwarded clock
rst  input  1  asynchronous active-high reset
enable  input  1  link enable; low forces IDLE and flushes FIFO
train_req  input  1  single-cycle pulse; re-enter TRAIN from PRIME/STREAM
s_data  input  16  sample word
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept a word
training  output  1  high while state is TRAIN
underflow_cnt  output  16  saturating count of STREAM cycles with empty FIFO
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
dac_clk_p/dac_clk_n  output  1  forwarded DDR clock (ODDRE1 D1=1, D2=0 -> OBUFDS)
dac_p/dac_n  output  8  DDR data lanes

Behaviour:
- Reset is asynchronous and active-high on every flop and on ODDRE1 SR; clock is clk only.
- Reset values: state IDLE, tx_word=IDLE_WORD, FIFO empty, fifo_level=0, underflow_cnt=0, training=0, s_ready=0; lane pins low.
- FIFO:
  - Synchronous, no fall-through; s_ready = (fifo_level < FIFO_DEPTH) and not in reset.
  - Push on s_valid&&s_ready; pop only in STREAM when level>0.
  - Simultaneous push and pop leaves the level unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Lane mapping: tx_word[2i] on ODDRE1 D1 (rising edge) and tx_word[2i+1] on D2 (falling edge) of lane i. This exactly inverts the receiver's Q1/Q2 mapping. ODDRE1 SRVAL=0, IS_C_INVERTED=0.
- Latency: a word popped in cycle N is in tx_word at N+1 and on the pins at N+2 (one ODDRE1 stage).
- State machine, registered, one transition per cycle:
  - IDLE: tx_word=IDLE_WORD; FIFO held flushed. -> TRAIN when enable=1.
  - TRAIN: tx_word=TRAIN_PATTERN; counter counts 0..TRAIN_CYCLES-1; training=1. -> PRIME when counter hits TRAIN_CYCLES-1. FIFO accepts writes.
  - PRIME: tx_word=IDLE_WORD. -> STREAM when fifo_level >= FIFO_DEPTH/2.
  - STREAM: pop each cycle; tx_word=popped word. If the FIFO is empty: tx_word=IDLE_WORD and underflow_cnt increments, saturating at 16'hFFFF. Stays in STREAM.
- Global transitions:
  - enable=0 in any state -> IDLE next cycle; FIFO flushed; underflow_cnt held.
  - train_req in PRIME/STREAM -> TRAIN with counter cleared; FIFO contents retained.
  - train_req in TRAIN restarts the counter.
  - train_req in IDLE is ignored.
  - enable=0 takes priority over train_req.
- Reset mid-stream: all of the above return immediately to reset values; no partial word is emitted after rst rises.
- underflow_cnt is cleared only by rst.

Optional Feature:
- DAC_TX_PRBS_EN defined:
  - TRAIN drives a PRBS7 sequence (x^7+x^6+1, seed 7'h7F, advanced 16 bits per clk, MSB-first into tx_word[15:0]) instead of TRAIN_PATTERN.
  - The LFSR reseeds on every entry to TRAIN.
- Not defined: fixed TRAIN_PATTERN; no LFSR logic is synthesised.

Decomposition:
- Package dac_ddr_pkg holds:
  - the state enum (IDLE, TRAIN, PRIME, STREAM);
  - defaults for TRAIN_PATTERN and IDLE_WORD;
  - the PRBS7 polynomial and seed;
  - the lane count (8) and word width (16), shared with the ADC receiver.
- One sub-module: dac_tx_fifo, a synchronous FIFO with async reset and level output, parameterised on width and depth.
- Primitive instantiation (ODDRE1/OBUFDS generate loop) stays in the top.

Test Plan:
- Reset then enable=1 -> training=1 for exactly 64 cycles with lanes carrying 16'hA55A (bits deserialised by a model IDDR). Then PRIME, and STREAM only after 8 words are written.
- In STREAM, push 0x0001..0x0100 at full rate -> same sequence recovered from the pins 2 cycles after pop; underflow_cnt=0.
- Stop s_valid after 8 words in STREAM -> 8 data words, then IDLE_WORD; underflow_cnt increments by 1 per cycle; s_ready=1 throughout.
- Hold s_valid=1 with no pops (PRIME, level<8 never reached cannot occur; instead force enable high in TRAIN for 64 cycles) -> fifo_level reaches 16 and s_ready drops to 0. No word is lost or duplicated.
- train_req pulse mid-STREAM -> TRAIN next cycle for 64 cycles; FIFO level preserved; stream resumes with the next unsent word.
- Assert rst asynchronously mid-STREAM (off clock edge) -> outputs return to reset values before the next clk edge; with DAC_TX_PRBS_EN defined, the first 16-bit TRAIN word after re-enable equals the reference PRBS7 model output for seed 7'h7F.
